// File: rtl/cernbe_bus_arbiter.sv
// Two-master arbiter in front of one cern-be-vme slave port.
// Round-robin grant, one outstanding access, per-access timeout.
module cernbe_bus_arbiter #(
    parameter int ADDR_WIDTH = 2,
    parameter int DATA_WIDTH = 16,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] m0_addr_i,
    input  logic [DATA_WIDTH-1:0] m0_wrdata_i,
    input  logic                  m0_rdmem_i,
    input  logic                  m0_wrmem_i,
    output logic [DATA_WIDTH-1:0] m0_rddata_o,
    output logic                  m0_rddone_o,
    output logic                  m0_wrdone_o,
    output logic                  m0_err_o,
    input  logic [ADDR_WIDTH-1:0] m1_addr_i,
    input  logic [DATA_WIDTH-1:0] m1_wrdata_i,
    input  logic                  m1_rdmem_i,
    input  logic                  m1_wrmem_i,
    output logic [DATA_WIDTH-1:0] m1_rddata_o,
    output logic                  m1_rddone_o,
    output logic                  m1_wrdone_o,
    output logic                  m1_err_o,
    output logic [ADDR_WIDTH-1:0] s_addr_o,
    output logic [DATA_WIDTH-1:0] s_wrdata_o,
    output logic                  s_rdmem_o,
    output logic                  s_wrmem_o,
    input  logic [DATA_WIDTH-1:0] s_rddata_i,
    input  logic                  s_rddone_i,
    input  logic                  s_wrdone_i
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    state_t state;
    state_t state_nxt;

    logic [1:0]            rd_strb;
    logic [1:0]            wr_strb;
    logic [ADDR_WIDTH-1:0] in_addr [2];
    logic [DATA_WIDTH-1:0] in_data [2];

    logic [1:0]            pend;
    logic [1:0]            slot_wr;
    logic [ADDR_WIDTH-1:0] slot_addr [2];
    logic [DATA_WIDTH-1:0] slot_data [2];

    logic                  gnt;
    logic                  last_grant;
    logic                  pick;
    logic [15:0]           cnt;
    logic                  cur_wr;
    logic                  done_match;
    logic                  tmo;
    logic                  complete;
    logic                  timed_out;
    logic [1:0]            own_done;

    logic [1:0]            rddone_q;
    logic [1:0]            wrdone_q;
    logic [1:0]            err_q;
    logic [DATA_WIDTH-1:0] rddata_q [2];

    assign rd_strb    = {m1_rdmem_i, m0_rdmem_i};
    assign wr_strb    = {m1_wrmem_i, m0_wrmem_i};
    assign in_addr[0] = m0_addr_i;
    assign in_addr[1] = m1_addr_i;
    assign in_data[0] = m0_wrdata_i;
    assign in_data[1] = m1_wrdata_i;

    assign cur_wr     = slot_wr[gnt];
    assign done_match = cur_wr ? s_wrdone_i : s_rddone_i;
    // cnt counts from the ISSUE cycle, so it equals cycles since the strobe
    assign tmo        = (state == WAIT) && (cnt >= TMO_LAST);
    assign complete   = (state != IDLE) && (done_match || tmo);
    assign timed_out  = complete && !done_match;
    assign own_done   = complete ? (gnt ? 2'b10 : 2'b01) : 2'b00;
    assign pick       = (pend == 2'b11) ? ~last_grant : pend[1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:        if (|pend) state_nxt = ISSUE;
            ISSUE, WAIT: state_nxt = complete ? IDLE : WAIT;
            default:     state_nxt = IDLE;
        endcase
    end

    always_comb begin
        s_rdmem_o  = 1'b0;
        s_wrmem_o  = 1'b0;
        s_addr_o   = '0;
        s_wrdata_o = '0;
        if (state == ISSUE) begin
            s_wrmem_o = cur_wr;
            s_rdmem_o = !cur_wr;
        end
        if (state != IDLE) begin
            s_addr_o   = slot_addr[gnt];
            s_wrdata_o = slot_data[gnt];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            gnt        <= 1'b0;
            last_grant <= 1'b1;
        end else begin
            if (state == IDLE && |pend) gnt <= pick;
            if (complete) last_grant <= gnt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (state == IDLE) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 16'd1;
        end
    end

    // A slot finishing at this edge is free for a new strobe at the same edge
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend    <= '0;
            slot_wr <= '0;
            for (int m = 0; m < 2; m++) begin
                slot_addr[m] <= '0;
                slot_data[m] <= '0;
            end
        end else begin
            for (int m = 0; m < 2; m++) begin
                if ((!pend[m] || own_done[m]) &&
                    (rd_strb[m] || wr_strb[m])) begin
                    pend[m]      <= 1'b1;
                    slot_wr[m]   <= wr_strb[m];
                    slot_addr[m] <= in_addr[m];
                    slot_data[m] <= in_data[m];
                end else if (own_done[m]) begin
                    pend[m] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rddone_q <= '0;
            wrdone_q <= '0;
            err_q    <= '0;
            for (int m = 0; m < 2; m++) begin
                rddata_q[m] <= '0;
            end
        end else begin
            for (int m = 0; m < 2; m++) begin
                rddone_q[m] <= own_done[m] && !cur_wr;
                wrdone_q[m] <= own_done[m] && cur_wr;
                err_q[m]    <= own_done[m] && timed_out;
                if (own_done[m] && !cur_wr) begin
                    rddata_q[m] <= timed_out ? '1 : s_rddata_i;
                end else begin
                    rddata_q[m] <= '0;
                end
            end
        end
    end

    assign m0_rddone_o = rddone_q[0];
    assign m0_wrdone_o = wrdone_q[0];
    assign m0_err_o    = err_q[0];
    assign m0_rddata_o = rddata_q[0];
    assign m1_rddone_o = rddone_q[1];
    assign m1_wrdone_o = wrdone_q[1];
    assign m1_err_o    = err_q[1];
    assign m1_rddata_o = rddata_q[1];

endmodule

// File: tb/tb_cernbe_bus_arbiter.sv
// Bench for cernbe_bus_arbiter: directed cases plus random traffic
// checked every cycle against a transaction-level model.
module tb_cernbe_bus_arbiter;

    localparam int AW  = 2;
    localparam int DW  = 16;
    localparam int TMO = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] m0_addr_i, m1_addr_i;
    logic [DW-1:0] m0_wrdata_i, m1_wrdata_i;
    logic          m0_rdmem_i, m0_wrmem_i, m1_rdmem_i, m1_wrmem_i;
    logic [DW-1:0] m0_rddata_o, m1_rddata_o;
    logic          m0_rddone_o, m0_wrdone_o, m0_err_o;
    logic          m1_rddone_o, m1_wrdone_o, m1_err_o;
    logic [AW-1:0] s_addr_o;
    logic [DW-1:0] s_wrdata_o;
    logic          s_rdmem_o, s_wrmem_o;
    logic [DW-1:0] s_rddata_i;
    logic          s_rddone_i, s_wrdone_i;

    always #5 clk = ~clk;

    cernbe_bus_arbiter #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_addr_i(m0_addr_i), .m0_wrdata_i(m0_wrdata_i),
        .m0_rdmem_i(m0_rdmem_i), .m0_wrmem_i(m0_wrmem_i),
        .m0_rddata_o(m0_rddata_o), .m0_rddone_o(m0_rddone_o),
        .m0_wrdone_o(m0_wrdone_o), .m0_err_o(m0_err_o),
        .m1_addr_i(m1_addr_i), .m1_wrdata_i(m1_wrdata_i),
        .m1_rdmem_i(m1_rdmem_i), .m1_wrmem_i(m1_wrmem_i),
        .m1_rddata_o(m1_rddata_o), .m1_rddone_o(m1_rddone_o),
        .m1_wrdone_o(m1_wrdone_o), .m1_err_o(m1_err_o),
        .s_addr_o(s_addr_o), .s_wrdata_o(s_wrdata_o),
        .s_rdmem_o(s_rdmem_o), .s_wrmem_o(s_wrmem_o),
        .s_rddata_i(s_rddata_i), .s_rddone_i(s_rddone_i),
        .s_wrdone_i(s_wrdone_i)
    );

    int errors = 0;
    int checks = 0;

    // Model: request slots, the active access and its age in cycles
    bit            mv = 0;
    bit            pend [2];
    bit            wr [2];
    logic [AW-1:0] ad [2];
    logic [DW-1:0] wd [2];
    bit            busy;
    int            own, age, last;
    bit            e_rdd [2], e_wrd [2], e_err [2];
    logic [DW-1:0] e_rdata [2];

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h @%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            pend[m] = 0; wr[m] = 0; ad[m] = '0; wd[m] = '0;
            e_rdd[m] = 0; e_wrd[m] = 0; e_err[m] = 0; e_rdata[m] = '0;
        end
        busy = 0; own = 0; age = 0; last = 1;
    endtask

    task automatic model_step();
        bit            rs [2], ws [2];
        logic [AW-1:0] ia [2];
        logic [DW-1:0] iw [2];
        bit            d, t;
        if (!rst_n) begin
            model_reset();
            mv = 1;
            return;
        end
        if (!mv) return;
        rs[0] = m0_rdmem_i; rs[1] = m1_rdmem_i;
        ws[0] = m0_wrmem_i; ws[1] = m1_wrmem_i;
        ia[0] = m0_addr_i;  ia[1] = m1_addr_i;
        iw[0] = m0_wrdata_i; iw[1] = m1_wrdata_i;
        for (int m = 0; m < 2; m++) begin
            e_rdd[m] = 0; e_wrd[m] = 0; e_err[m] = 0; e_rdata[m] = '0;
        end
        if (busy) begin
            d = wr[own] ? s_wrdone_i : s_rddone_i;
            t = !d && age >= 1 && age >= TMO - 1;
            if (d || t) begin
                if (wr[own]) e_wrd[own] = 1;
                else begin
                    e_rdd[own] = 1;
                    e_rdata[own] = t ? {DW{1'b1}} : s_rddata_i;
                end
                e_err[own] = t;
                pend[own] = 0;
                last = own;
                busy = 0;
            end else begin
                age++;
            end
        end else if (pend[0] || pend[1]) begin
            if (pend[0] && pend[1]) own = (last == 0) ? 1 : 0;
            else own = pend[0] ? 0 : 1;
            busy = 1;
            age = 0;
        end
        for (int m = 0; m < 2; m++) begin
            if ((rs[m] || ws[m]) && !pend[m]) begin
                pend[m] = 1; wr[m] = ws[m]; ad[m] = ia[m]; wd[m] = iw[m];
            end
        end
    endtask

    task automatic compare_all();
        if (!mv) return;
        chk("s_rdmem", s_rdmem_o, busy && age == 0 && !wr[own]);
        chk("s_wrmem", s_wrmem_o, busy && age == 0 && wr[own]);
        chk("s_addr", s_addr_o, busy ? 32'(ad[own]) : 32'd0);
        chk("s_wrdata", s_wrdata_o, busy ? 32'(wd[own]) : 32'd0);
        chk("m0_rddone", m0_rddone_o, e_rdd[0]);
        chk("m0_wrdone", m0_wrdone_o, e_wrd[0]);
        chk("m0_err", m0_err_o, e_err[0]);
        chk("m0_rddata", m0_rddata_o, e_rdata[0]);
        chk("m1_rddone", m1_rddone_o, e_rdd[1]);
        chk("m1_wrdone", m1_wrdone_o, e_wrd[1]);
        chk("m1_err", m1_err_o, e_err[1]);
        chk("m1_rddata", m1_rddata_o, e_rdata[1]);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic clear_in();
        m0_rdmem_i = 0; m0_wrmem_i = 0; m1_rdmem_i = 0; m1_wrmem_i = 0;
        m0_addr_i = '0; m1_addr_i = '0; m0_wrdata_i = '0; m1_wrdata_i = '0;
        s_rddone_i = 0; s_wrdone_i = 0; s_rddata_i = '0;
    endtask

    task automatic reset_dut();
        clear_in();
        rst_n = 0;
        tick();
        tick();
        rst_n = 1;
    endtask

    task automatic respond();
        s_wrdone_i = s_wrmem_o;
        s_rddone_i = s_rdmem_o;
        s_rddata_i = 16'h0F0F;
    endtask

    task automatic drain();
        repeat (12) begin
            respond();
            tick();
            clear_in();
        end
    endtask

    task automatic do_t1(string tag);
        m0_wrmem_i = 1; m0_addr_i = 2'd1; m0_wrdata_i = 16'h1234;
        tick();
        clear_in();
        chk({tag, "_n1_quiet"}, s_wrmem_o, 0);
        tick();
        chk({tag, "_s_wrmem"}, s_wrmem_o, 1);
        chk({tag, "_s_wrdata"}, s_wrdata_o, 16'h1234);
        chk({tag, "_s_addr"}, s_addr_o, 1);
        s_wrdone_i = 1;
        tick();
        clear_in();
        chk({tag, "_wrdone"}, m0_wrdone_o, 1);
        chk({tag, "_err"}, m0_err_o, 0);
        tick();
        chk({tag, "_pulse"}, m0_wrdone_o, 0);
    endtask

    initial begin
        int ord[$];
        int exp_ord[6];
        int ovl;
        int nstrb, ndone;
        logic [DW-1:0] seen;

        exp_ord = '{0, 1, 0, 1, 0, 1};
        reset_dut();
        chk("rst_s_rdmem", s_rdmem_o, 0);
        chk("rst_s_addr", s_addr_o, 0);
        chk("rst_m1_err", m1_err_o, 0);

        do_t1("t1");

        // Both masters request together; each re-requests while its access
        // is being answered, so every grant decision is a tie
        reset_dut();
        ovl = 0;
        m0_rdmem_i = 1; m0_addr_i = 2'd2;
        m1_wrmem_i = 1; m1_addr_i = 2'd3; m1_wrdata_i = 16'hBEEF;
        tick();
        clear_in();
        for (int c = 0; c < 60 && ord.size() < 6; c++) begin
            if (s_rdmem_o && s_wrmem_o) ovl++;
            if (m0_rddone_o) ord.push_back(0);
            if (m1_wrdone_o) ord.push_back(1);
            if (s_rdmem_o || s_wrmem_o) begin
                respond();
                m0_rdmem_i = 1; m0_addr_i = 2'd2;
                m1_wrmem_i = 1; m1_addr_i = 2'd3; m1_wrdata_i = 16'hBEEF;
            end
            tick();
            clear_in();
        end
        chk("t3_count", ord.size(), 6);
        for (int i = 0; i < 6; i++) begin
            chk("t3_order", (i < ord.size()) ? ord[i] : 99, exp_ord[i]);
        end
        chk("t2_overlap", ovl, 0);
        drain();

        // Read with no slave answer
        m1_rdmem_i = 1; m1_addr_i = 2'd0;
        tick();
        clear_in();
        tick();
        chk("t4_s_rdmem", s_rdmem_o, 1);
        repeat (7) tick();
        chk("t4_early", m1_rddone_o, 0);
        tick();
        chk("t4_rddone", m1_rddone_o, 1);
        chk("t4_err", m1_err_o, 1);
        chk("t4_rddata", m1_rddata_o, 16'hFFFF);
        chk("t4_m0_quiet", m0_rddone_o, 0);
        s_rddone_i = 1; s_rddata_i = 16'h5555;
        tick();
        clear_in();
        chk("t4_late_done", m1_rddone_o, 0);
        chk("t4_late_err", m1_err_o, 0);
        tick();
        chk("t4_idle", s_rdmem_o, 0);

        // Second strobe while pending is dropped
        m0_wrmem_i = 1; m0_addr_i = 2'd2; m0_wrdata_i = 16'hAAAA;
        tick();
        clear_in();
        m0_wrmem_i = 1; m0_addr_i = 2'd3; m0_wrdata_i = 16'hBBBB;
        tick();
        clear_in();
        nstrb = 0; ndone = 0; seen = '0;
        repeat (10) begin
            if (s_wrmem_o) begin nstrb++; seen = s_wrdata_o; end
            if (m0_wrdone_o) ndone++;
            respond();
            tick();
            clear_in();
        end
        chk("t5_strobes", nstrb, 1);
        chk("t5_dones", ndone, 1);
        chk("t5_data", seen, 16'hAAAA);

        // Reset in the middle of a wait
        m1_wrmem_i = 1; m1_addr_i = 2'd1; m1_wrdata_i = 16'h7777;
        tick();
        clear_in();
        repeat (3) tick();
        rst_n = 0;
        tick();
        chk("t6_s_addr", s_addr_o, 0);
        chk("t6_s_wrdata", s_wrdata_o, 0);
        rst_n = 1;
        repeat (3) begin
            tick();
            chk("t6_nodone", m1_wrdone_o | m1_err_o, 0);
        end
        do_t1("t6");

        // Random traffic against the model
        repeat (3000) begin
            m0_rdmem_i  = ($urandom_range(0, 5) == 0);
            m0_wrmem_i  = ($urandom_range(0, 5) == 0);
            m1_rdmem_i  = ($urandom_range(0, 5) == 0);
            m1_wrmem_i  = ($urandom_range(0, 5) == 0);
            m0_addr_i   = AW'($urandom);
            m1_addr_i   = AW'($urandom);
            m0_wrdata_i = DW'($urandom);
            m1_wrdata_i = DW'($urandom);
            s_rddone_i  = ($urandom_range(0, 4) == 0);
            s_wrdone_i  = ($urandom_range(0, 4) == 0);
            s_rddata_i  = DW'($urandom);
            rst_n       = ($urandom_range(0, 299) != 0);
            tick();
        end
        clear_in();
        rst_n = 1;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
